// File: rtl/mem_responder.sv
// mem_responder
//   Memory-mapped responder: a RAM of 2^RAM_AW 16-bit words, a byte-wide TX
//   FIFO, a STATUS register and a free-running CYCLES counter.
//
//   Address map (16-bit): RAM where addr >> RAM_AW == 0, TXDATA 0xF000
//   (write pushes a byte, read returns 0), STATUS 0xF001
//   (bit0 empty, bit1 full, bit2 overflow, bits[7:4] count), CYCLES 0xF002.
//   Every other address reads as zero and ignores writes.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_raddr_i/rd_i    read address / enable; mem_rdata_o is valid one cycle later
//   mem_waddr_i/wdata_i write address / data, committed at the edge with mem_wr_i=1
//   tx_data_o/valid_o   TX FIFO head byte / non-empty flag
//   tx_ready_i          downstream accepts the head byte
module mem_responder #(
  parameter int RAM_AW     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_raddr_i,
  input  logic        mem_rd_i,
  output logic [15:0] mem_rdata_o,
  input  logic [15:0] mem_waddr_i,
  input  logic [15:0] mem_wdata_i,
  input  logic        mem_wr_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [15:0] ADDR_TXDATA = 16'hF000;
  localparam logic [15:0] ADDR_STATUS = 16'hF001;
  localparam logic [15:0] ADDR_CYCLES = 16'hF002;

  logic [15:0]   ram [2**RAM_AW];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   cycles;

  logic          rd_ram_hit;
  logic          wr_ram_hit;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic [3:0]    status_cnt;
  logic [15:0]   status_word;
  logic [15:0]   rd_mux;

  assign rd_ram_hit = (mem_raddr_i >> RAM_AW) == 16'd0;
  assign wr_ram_hit = (mem_waddr_i >> RAM_AW) == 16'd0;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  // Full is judged on the pre-edge count, so a same-cycle pop never makes
  // room for a push into a full FIFO.
  assign push_req = mem_wr_i && (mem_waddr_i == ADDR_TXDATA);
  assign push     = push_req && !fifo_full;
  assign pop      = tx_valid_o && tx_ready_i;
  assign ovf_clr  = mem_wr_i && (mem_waddr_i == ADDR_STATUS) && mem_wdata_i[2];

  assign status_cnt  = 4'(count);
  assign status_word = {8'h00, status_cnt, 1'b0, overflow, fifo_full, fifo_empty};

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Read mux sees the RAM before this edge's write lands: read-first.
  always_comb begin
    rd_mux = 16'h0000;
    if (rd_ram_hit) begin
      rd_mux = ram[mem_raddr_i[RAM_AW-1:0]];
    end else begin
      case (mem_raddr_i)
        ADDR_STATUS: rd_mux = status_word;
        ADDR_CYCLES: rd_mux = cycles;
        default:     rd_mux = 16'h0000;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_i && wr_ram_hit) begin
      ram[mem_waddr_i[RAM_AW-1:0]] <= mem_wdata_i;
    end
  end

  // Storage writes during reset are harmless: the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata_o <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      cycles      <= 16'h0000;
    end else begin
      cycles <= cycles + 16'd1;
      if (mem_rd_i) begin
        mem_rdata_o <= rd_mux;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push outranks a same-cycle clear.
      if (push_req && fifo_full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_raddr_i = 16'h0000;
  logic        mem_rd_i = 1'b0;
  logic [15:0] mem_rdata_o;
  logic [15:0] mem_waddr_i = 16'h0000;
  logic [15:0] mem_wdata_i = 16'h0000;
  logic        mem_wr_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_responder #(.RAM_AW(12), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .mem_raddr_i(mem_raddr_i),
    .mem_rd_i(mem_rd_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wr_i(mem_wr_i),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] ram_m [4096];
  bit          ram_k [4096];
  logic [7:0]  q [$];
  bit          ovf = 1'b0;
  logic [15:0] cyc = 16'h0000;
  logic [15:0] exp_rdata = 16'h0000;
  bit          rd_known = 1'b1;
  bit          chk_en = 1'b0;

  function automatic logic [15:0] status_m();
    int v;
    v = q.size() * 16 + (ovf ? 4 : 0) + ((q.size() == DEPTH) ? 2 : 0) + ((q.size() == 0) ? 1 : 0);
    return 16'(v);
  endfunction

  always @(posedge clk) begin : model
    bit full_m;
    bit pop_m;
    bit push_m;
    if (reset) begin
      q.delete();
      ovf       = 1'b0;
      cyc       = 16'h0000;
      exp_rdata = 16'h0000;
      rd_known  = 1'b1;
    end else begin
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() != 0) && tx_ready_i;
      push_m = 1'b0;
      if (mem_rd_i) begin
        rd_known = 1'b1;
        if (mem_raddr_i < 16'h1000) begin
          if (ram_k[mem_raddr_i[11:0]]) exp_rdata = ram_m[mem_raddr_i[11:0]];
          else rd_known = 1'b0;
        end else if (mem_raddr_i == 16'hF001) exp_rdata = status_m();
        else if (mem_raddr_i == 16'hF002) exp_rdata = cyc;
        else exp_rdata = 16'h0000;
      end
      if (mem_wr_i) begin
        if (mem_waddr_i < 16'h1000) begin
          ram_m[mem_waddr_i[11:0]] = mem_wdata_i;
          ram_k[mem_waddr_i[11:0]] = 1'b1;
        end else if (mem_waddr_i == 16'hF000) begin
          if (full_m) ovf = 1'b1;
          else push_m = 1'b1;
        end else if (mem_waddr_i == 16'hF001 && mem_wdata_i[2]) begin
          ovf = 1'b0;
        end
      end
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(mem_wdata_i[7:0]);
      cyc = cyc + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (rd_known) chk("rdata_model", mem_rdata_o, exp_rdata);
      chk("valid_model", {15'h0, tx_valid_o}, {15'h0, q.size() != 0});
      chk("txdata_model", {8'h00, tx_data_o}, {8'h00, (q.size() != 0) ? q[0] : 8'h00});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_waddr_i = a;
    mem_wdata_i = d;
    mem_wr_i    = 1'b1;
    tick();
    mem_wr_i    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_raddr_i = a;
    mem_rd_i    = 1'b1;
    tick();
    mem_rd_i    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("reset_rdata", mem_rdata_o, 16'h0000);
    chk("reset_valid", {15'h0, tx_valid_o}, 16'h0000);
    chk("reset_txdata", {8'h00, tx_data_o}, 16'h0000);
    tick();
    reset = 1'b0;

    // RAM write / read / read-first
    wr(16'h0005, 16'h1234);
    rd(16'h0005);
    chk("ram_read", mem_rdata_o, 16'h1234);
    tick();
    chk("rdata_hold", mem_rdata_o, 16'h1234);
    mem_raddr_i = 16'h0005; mem_rd_i = 1'b1;
    mem_waddr_i = 16'h0005; mem_wdata_i = 16'hBEEF; mem_wr_i = 1'b1;
    tick();
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    chk("read_first", mem_rdata_o, 16'h1234);
    rd(16'h0005);
    chk("ram_new", mem_rdata_o, 16'hBEEF);
    wr(16'h1005, 16'hDEAD);
    rd(16'h1005);
    chk("unmapped_read", mem_rdata_o, 16'h0000);
    rd(16'h0005);
    chk("unmapped_wr_ignored", mem_rdata_o, 16'hBEEF);
    rd(16'hF000);
    chk("txdata_read", mem_rdata_o, 16'h0000);

    // FIFO fill past depth with downstream stalled
    tx_ready_i  = 1'b0;
    mem_waddr_i = 16'hF000; mem_wdata_i = 16'h0041; mem_wr_i = 1'b1;
    #1;
    chk("no_comb_valid", {15'h0, tx_valid_o}, 16'h0000);
    tick();
    mem_wr_i = 1'b0;
    chk("valid_after_push", {15'h0, tx_valid_o}, 16'h0001);
    for (int i = 1; i < 9; i++) wr(16'hF000, 16'(16'h0041 + i));
    rd(16'hF001);
    chk("status_full_ovf", mem_rdata_o, 16'h0086);
    tick();
    chk("stall_stable", {8'h00, tx_data_o}, 16'h0041);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", {8'h00, tx_data_o}, 16'(16'h0041 + i));
      tick();
    end
    chk("drained_valid", {15'h0, tx_valid_o}, 16'h0000);
    tx_ready_i = 1'b0;

    // overflow clear
    wr(16'hF001, 16'h0004);
    rd(16'hF001);
    chk("status_cleared", mem_rdata_o, 16'h0001);

    // push into full FIFO while a pop happens
    for (int i = 0; i < 8; i++) wr(16'hF000, 16'(16'h0060 + i));
    mem_waddr_i = 16'hF000; mem_wdata_i = 16'h0055; mem_wr_i = 1'b1;
    tx_ready_i  = 1'b1;
    tick();
    mem_wr_i = 1'b0; tx_ready_i = 1'b0;
    chk("full_pop_head", {8'h00, tx_data_o}, 16'h0061);
    rd(16'hF001);
    chk("status_drop", mem_rdata_o, 16'h0074);
    tx_ready_i = 1'b1;
    repeat (7) tick();
    chk("drop_drained", {15'h0, tx_valid_o}, 16'h0000);
    tx_ready_i = 1'b0;

    // reset mid-operation
    wr(16'h0005, 16'h1234);
    for (int i = 0; i < 3; i++) wr(16'hF000, 16'(16'h00A1 + i));
    mem_raddr_i = 16'h0005; mem_rd_i = 1'b1;
    mem_waddr_i = 16'hF000; mem_wdata_i = 16'h00A4; mem_wr_i = 1'b1;
    reset = 1'b1;
    tick();
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    chk("rst_mid_valid", {15'h0, tx_valid_o}, 16'h0000);
    chk("rst_mid_rdata", mem_rdata_o, 16'h0000);
    reset = 1'b0;
    rd(16'h0005);
    chk("ram_survives_rst", mem_rdata_o, 16'h1234);
    rd(16'hF001);
    chk("status_after_rst", mem_rdata_o, 16'h0001);

    // CYCLES wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    rd(16'hF002);
    chk("cycles_3", mem_rdata_o, 16'h0003);
    wr(16'hF002, 16'h7777);
    repeat (65534) tick();
    rd(16'hF002);
    chk("cycles_65539", mem_rdata_o, 16'h0003);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
